// File: rtl/fgmt_thread_sched_pkg.sv
// Shared fetch-stage definitions for the fine-grained multithreading scheduler.
// Provides the default pool size and derived thread ID width, the word type,
// the bubble PC value, the scheduling mode encoding, and a thread-ID to
// one-hot helper.
package fgmt_thread_sched_pkg;

  localparam int unsigned THREAD_POOL_SIZE = 4;
  localparam int unsigned MAX_THREADS      = 16;
  localparam int unsigned TID_BITS         = $clog2(THREAD_POOL_SIZE);
  localparam int unsigned WIDTH            = 32;

  typedef logic [WIDTH-1:0] word_t;

  // PC value presented on an empty (bubble) fetch slot
  localparam word_t BUBBLE = '0;

  typedef enum logic {
    SCHED_BARREL = 1'b0,
    SCHED_SKIP   = 1'b1
  } sched_mode_e;

  // One-hot active-thread encoding for any pool size up to MAX_THREADS
  function automatic logic [MAX_THREADS-1:0] tid2onehot(input logic [3:0] tid);
    tid2onehot = MAX_THREADS'(1) << tid;
  endfunction

endpackage

// File: rtl/fgmt_rr_arbiter.sv
// Combinational rotating-priority picker.
// Ports: req         - per-thread request bits
//        ptr         - index holding highest priority this cycle
//        grant_valid - at least one request present
//        grant_tid   - first requesting index at or after ptr (wrapping)
module fgmt_rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned TID_BITS = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [TID_BITS-1:0] ptr,
  output logic                grant_valid,
  output logic [TID_BITS-1:0] grant_tid
);

  logic [TID_BITS-1:0] cand;

  // Scan ptr, ptr+1, ... mod N; the first hit wins
  always_comb begin
    grant_valid = 1'b0;
    grant_tid   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = TID_BITS'((32'(ptr) + i) % N);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_tid   = cand;
      end
    end
  end

endmodule

// File: rtl/fgmt_thread_sched.sv
// Fine-grained multithreading fetch scheduler.
// Picks one eligible hardware thread per accepted slot and presents its PC,
// thread ID and one-hot vector from registers; empty slots are bubbles.
// Tracks per-thread stall state from L1 miss/fill reports and per-thread PCs
// with redirect.
// Ports: clk, rst_n (sync, active low)
//        thread_en                            - per-thread enable mask
//        redirect_valid/redirect_tid/redirect_pc - PC overwrite request
//        miss_valid/miss_tid                  - stall a thread
//        fill_valid/fill_tid                  - release a thread
//        fetch_ready                          - downstream accepts the slot
//        fetch_valid/fetch_tid/fetch_onehot/fetch_pc - current fetch slot
//        stalled_mask                         - per-thread stall bits
module fgmt_thread_sched
  import fgmt_thread_sched_pkg::*;
#(
  parameter int unsigned      THREAD_POOL_SIZE = 4,
  parameter int unsigned      TID_BITS         = $clog2(THREAD_POOL_SIZE),
  parameter int unsigned      WIDTH            = 32,
  parameter int unsigned      SCHED_MODE       = 1,
  parameter logic [WIDTH-1:0] RESET_PC         = '0,
  parameter logic [WIDTH-1:0] PC_STRIDE        = WIDTH'(32'h1000)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [THREAD_POOL_SIZE-1:0] thread_en,
  input  logic                        redirect_valid,
  input  logic [TID_BITS-1:0]         redirect_tid,
  input  logic [WIDTH-1:0]            redirect_pc,
  input  logic                        miss_valid,
  input  logic [TID_BITS-1:0]         miss_tid,
  input  logic                        fill_valid,
  input  logic [TID_BITS-1:0]         fill_tid,
  input  logic                        fetch_ready,
  output logic                        fetch_valid,
  output logic [TID_BITS-1:0]         fetch_tid,
  output logic [THREAD_POOL_SIZE-1:0] fetch_onehot,
  output logic [WIDTH-1:0]            fetch_pc,
  output logic [THREAD_POOL_SIZE-1:0] stalled_mask
);

  localparam int unsigned         N        = THREAD_POOL_SIZE;
  localparam logic [TID_BITS-1:0] LAST_TID = TID_BITS'(N - 1);
  localparam bit                  BARREL   = (SCHED_MODE == 32'(SCHED_BARREL));

  logic [WIDTH-1:0]    pc_q [N];
  logic [TID_BITS-1:0] rr_ptr;
  logic [N-1:0]        elig_c;
  logic                arb_valid;
  logic [TID_BITS-1:0] arb_tid;
  logic                load_c;
  logic                issue_c;
  logic [TID_BITS-1:0] issue_tid_c;
  logic [TID_BITS-1:0] next_ptr_c;
  logic [WIDTH-1:0]    issue_pc_c;

  function automatic logic [TID_BITS-1:0] next_tid(input logic [TID_BITS-1:0] t);
    next_tid = (t == LAST_TID) ? '0 : t + TID_BITS'(1);
  endfunction

  assign elig_c = thread_en & ~stalled_mask;

  fgmt_rr_arbiter #(
    .N        (N),
    .TID_BITS (TID_BITS)
  ) u_arb (
    .req         (elig_c),
    .ptr         (rr_ptr),
    .grant_valid (arb_valid),
    .grant_tid   (arb_tid)
  );

  // Slot selection: barrel tries only the slot owner, skip mode takes the first eligible
  always_comb begin
    load_c      = !fetch_valid || fetch_ready;
    issue_c     = 1'b0;
    issue_tid_c = rr_ptr;
    next_ptr_c  = rr_ptr;
    if (BARREL) begin
      issue_c     = elig_c[rr_ptr];
      issue_tid_c = rr_ptr;
      next_ptr_c  = next_tid(rr_ptr);
    end else begin
      issue_c     = arb_valid;
      issue_tid_c = arb_tid;
      next_ptr_c  = arb_valid ? next_tid(arb_tid) : rr_ptr;
    end
    issue_pc_c = pc_q[issue_tid_c];
  end

  // Fetch slot register; held while downstream back-pressures a valid slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      fetch_valid  <= 1'b0;
      fetch_tid    <= '0;
      fetch_onehot <= '0;
      fetch_pc     <= '0;
    end else if (load_c) begin
      rr_ptr      <= next_ptr_c;
      fetch_valid <= issue_c;
      if (issue_c) begin
        fetch_tid    <= issue_tid_c;
        fetch_onehot <= N'(tid2onehot(4'(issue_tid_c)));
        fetch_pc     <= issue_pc_c;
      end else begin
        fetch_tid    <= '0;
        fetch_onehot <= '0;
        fetch_pc     <= WIDTH'(BUBBLE);
      end
    end
  end

  // Per-thread PC and stall state; redirect overrides the issue increment,
  // miss overrides a same-cycle fill
  for (genvar t = 0; t < N; t++) begin : g_thr
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pc_q[t]         <= RESET_PC + WIDTH'(t) * PC_STRIDE;
        stalled_mask[t] <= 1'b0;
      end else begin
        if (load_c && issue_c && (issue_tid_c == TID_BITS'(t))) begin
          pc_q[t] <= pc_q[t] + WIDTH'(4);
        end
        if (redirect_valid && (redirect_tid == TID_BITS'(t))) begin
          pc_q[t] <= redirect_pc;
        end
        if (miss_valid && (miss_tid == TID_BITS'(t))) begin
          stalled_mask[t] <= 1'b1;
        end else if (fill_valid && (fill_tid == TID_BITS'(t))) begin
          stalled_mask[t] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fgmt_thread_sched.sv
// Scoreboard bench for fgmt_thread_sched: a skip-mode and a barrel-mode
// instance share stimulus; expected slots are queued per instance and a
// negedge monitor pops and compares them.
module tb_fgmt_thread_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  thread_en;
  logic        redirect_valid;
  logic [1:0]  redirect_tid;
  logic [31:0] redirect_pc;
  logic        miss_valid;
  logic [1:0]  miss_tid;
  logic        fill_valid;
  logic [1:0]  fill_tid;
  logic        fetch_ready;

  logic        o1_valid, o0_valid;
  logic [1:0]  o1_tid, o0_tid;
  logic [3:0]  o1_oh, o0_oh;
  logic [31:0] o1_pc, o0_pc;
  logic [3:0]  o1_mask, o0_mask;

  typedef struct {
    logic        v;
    logic [1:0]  tid;
    logic [31:0] pc;
    logic [3:0]  mask;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fgmt_thread_sched #(.THREAD_POOL_SIZE(4), .SCHED_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .thread_en(thread_en),
    .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
    .miss_valid(miss_valid), .miss_tid(miss_tid),
    .fill_valid(fill_valid), .fill_tid(fill_tid),
    .fetch_ready(fetch_ready),
    .fetch_valid(o1_valid), .fetch_tid(o1_tid), .fetch_onehot(o1_oh),
    .fetch_pc(o1_pc), .stalled_mask(o1_mask)
  );

  fgmt_thread_sched #(.THREAD_POOL_SIZE(4), .SCHED_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .thread_en(thread_en),
    .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
    .miss_valid(miss_valid), .miss_tid(miss_tid),
    .fill_valid(fill_valid), .fill_tid(fill_tid),
    .fetch_ready(fetch_ready),
    .fetch_valid(o0_valid), .fetch_tid(o0_tid), .fetch_onehot(o0_oh),
    .fetch_pc(o0_pc), .stalled_mask(o0_mask)
  );

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (mode%0d) t=%0t: got 0x%0h expected 0x%0h", name, d, $time, act, exp);
    end
  endtask

  task automatic check_slot(input int d, input exp_t e, input logic v, input logic [1:0] tid,
                            input logic [3:0] oh, input logic [31:0] pc, input logic [3:0] mask);
    logic [3:0] eoh;
    eoh = e.v ? (4'b0001 << e.tid) : 4'b0000;
    chk("fetch_valid", d, 32'(v), 32'(e.v));
    if (e.v) chk("fetch_tid", d, 32'(tid), 32'(e.tid));
    chk("fetch_onehot", d, 32'(oh), 32'(eoh));
    chk("fetch_pc", d, pc, e.pc);
    chk("stalled_mask", d, 32'(mask), 32'(e.mask));
  endtask

  // Monitor: compare whatever expectations are pending, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check_slot(1, e, o1_valid, o1_tid, o1_oh, o1_pc, o1_mask);
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check_slot(0, e, o0_valid, o0_tid, o0_oh, o0_pc, o0_mask);
    end
  end

  // One clock; queue the slot each instance must show after this edge
  task automatic tick(input logic v1, input int t1, input logic [31:0] p1,
                      input logic v0, input int t0, input logic [31:0] p0,
                      input logic [3:0] m);
    exp_t e;
    @(posedge clk);
    #1;
    e.v = v1; e.tid = 2'(t1); e.pc = p1; e.mask = m;
    q1.push_back(e);
    e.v = v0; e.tid = 2'(t0); e.pc = p0; e.mask = m;
    q0.push_back(e);
  endtask

  task automatic clr();
    redirect_valid = 1'b0;
    miss_valid     = 1'b0;
    fill_valid     = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    thread_en   = 4'hF;
    fetch_ready = 1'b1;
    rst_n       = 1'b0;
    tick(0, 0, 32'h0, 0, 0, 32'h0, 4'b0000);
    tick(0, 0, 32'h0, 0, 0, 32'h0, 4'b0000);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; thread_en = 4'hF; fetch_ready = 1'b1;
    redirect_valid = 1'b0; redirect_tid = '0; redirect_pc = '0;
    miss_valid = 1'b0; miss_tid = '0; fill_valid = 1'b0; fill_tid = '0;

    // Plain rotation, all threads eligible
    do_reset();
    tick(1, 0, 32'h0,    1, 0, 32'h0,    4'b0000);
    tick(1, 1, 32'h1000, 1, 1, 32'h1000, 4'b0000);
    tick(1, 2, 32'h2000, 1, 2, 32'h2000, 4'b0000);
    tick(1, 3, 32'h3000, 1, 3, 32'h3000, 4'b0000);
    tick(1, 0, 32'h4,    1, 0, 32'h4,    4'b0000);

    // Thread 1 stalled by a miss, released by a fill
    do_reset();
    miss_valid = 1'b1; miss_tid = 2'd1;
    tick(1, 0, 32'h0,    1, 0, 32'h0,    4'b0010);
    clr();
    tick(1, 2, 32'h2000, 0, 0, 32'h0,    4'b0010);
    tick(1, 3, 32'h3000, 1, 2, 32'h2000, 4'b0010);
    tick(1, 0, 32'h4,    1, 3, 32'h3000, 4'b0010);
    tick(1, 2, 32'h2004, 1, 0, 32'h4,    4'b0010);
    tick(1, 3, 32'h3004, 0, 0, 32'h0,    4'b0010);
    tick(1, 0, 32'h8,    1, 2, 32'h2004, 4'b0010);
    fill_valid = 1'b1; fill_tid = 2'd1;
    tick(1, 2, 32'h2008, 1, 3, 32'h3004, 4'b0000);
    clr();
    tick(1, 3, 32'h3008, 1, 0, 32'h8,    4'b0000);
    tick(1, 0, 32'hC,    1, 1, 32'h1000, 4'b0000);
    tick(1, 1, 32'h1000, 1, 2, 32'h2008, 4'b0000);
    tick(1, 2, 32'h200C, 1, 3, 32'h3008, 4'b0000);

    // Back-pressure holds slot tid 2; a redirect during the hold leaves it intact
    do_reset();
    tick(1, 0, 32'h0,    1, 0, 32'h0,    4'b0000);
    tick(1, 1, 32'h1000, 1, 1, 32'h1000, 4'b0000);
    tick(1, 2, 32'h2000, 1, 2, 32'h2000, 4'b0000);
    fetch_ready = 1'b0;
    tick(1, 2, 32'h2000, 1, 2, 32'h2000, 4'b0000);
    redirect_valid = 1'b1; redirect_tid = 2'd3; redirect_pc = 32'h500;
    tick(1, 2, 32'h2000, 1, 2, 32'h2000, 4'b0000);
    clr();
    tick(1, 2, 32'h2000, 1, 2, 32'h2000, 4'b0000);
    fetch_ready = 1'b1;
    tick(1, 3, 32'h500,  1, 3, 32'h500,  4'b0000);
    tick(1, 0, 32'h4,    1, 0, 32'h4,    4'b0000);
    tick(1, 1, 32'h1004, 1, 1, 32'h1004, 4'b0000);

    // Redirect of thread 0 in the cycle it issues
    do_reset();
    redirect_valid = 1'b1; redirect_tid = 2'd0; redirect_pc = 32'h80;
    tick(1, 0, 32'h0,    1, 0, 32'h0,    4'b0000);
    clr();
    tick(1, 1, 32'h1000, 1, 1, 32'h1000, 4'b0000);
    tick(1, 2, 32'h2000, 1, 2, 32'h2000, 4'b0000);
    tick(1, 3, 32'h3000, 1, 3, 32'h3000, 4'b0000);
    tick(1, 0, 32'h80,   1, 0, 32'h80,   4'b0000);
    tick(1, 1, 32'h1004, 1, 1, 32'h1004, 4'b0000);

    // Thread 2 disabled; its stall bit still tracks a miss
    do_reset();
    thread_en = 4'b1011;
    miss_valid = 1'b1; miss_tid = 2'd2;
    tick(1, 0, 32'h0,    1, 0, 32'h0,    4'b0100);
    clr();
    tick(1, 1, 32'h1000, 1, 1, 32'h1000, 4'b0100);
    tick(1, 3, 32'h3000, 0, 0, 32'h0,    4'b0100);
    tick(1, 0, 32'h4,    1, 3, 32'h3000, 4'b0100);
    tick(1, 1, 32'h1004, 1, 0, 32'h4,    4'b0100);

    // Same-cycle miss+fill on tid 3, then stall every thread, then reset mid-run
    do_reset();
    miss_valid = 1'b1; miss_tid = 2'd3; fill_valid = 1'b1; fill_tid = 2'd3;
    tick(1, 0, 32'h0,    1, 0, 32'h0,    4'b1000);
    clr();
    tick(1, 1, 32'h1000, 1, 1, 32'h1000, 4'b1000);
    tick(1, 2, 32'h2000, 1, 2, 32'h2000, 4'b1000);
    tick(1, 0, 32'h4,    0, 0, 32'h0,    4'b1000);
    miss_valid = 1'b1; miss_tid = 2'd0;
    tick(1, 1, 32'h1004, 1, 0, 32'h4,    4'b1001);
    miss_tid = 2'd1;
    tick(1, 2, 32'h2004, 1, 1, 32'h1004, 4'b1011);
    miss_tid = 2'd2;
    tick(1, 2, 32'h2008, 1, 2, 32'h2004, 4'b1111);
    clr();
    tick(0, 0, 32'h0,    0, 0, 32'h0,    4'b1111);
    tick(0, 0, 32'h0,    0, 0, 32'h0,    4'b1111);
    tick(0, 0, 32'h0,    0, 0, 32'h0,    4'b1111);
    rst_n = 1'b0;
    tick(0, 0, 32'h0,    0, 0, 32'h0,    4'b0000);
    rst_n = 1'b1;
    tick(1, 0, 32'h0,    1, 0, 32'h0,    4'b0000);
    tick(1, 1, 32'h1000, 1, 1, 32'h1000, 4'b0000);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fgmt_thread_sched.md
Name: fgmt_thread_sched

Overview:
- Parametrised fine-grained multithreading thread scheduler for the fetch stage.
- Each cycle it picks one hardware thread to fetch and drives that thread's PC, CTID and one-hot active-thread vector. It inserts a bubble when no thread is eligible.
- It tracks per-thread stall state from L1 miss and fill notifications, and per-thread PCs with redirect.
- Generalises the fixed 4-thread encoding to N threads and adds two scheduling modes.

Parameters:
- THREAD_POOL_SIZE, 4: number of hardware threads N (legal range 2..16).
- TID_BITS, $clog2(THREAD_POOL_SIZE): thread ID width.
- WIDTH, 32: PC/word width.
- SCHED_MODE, 1: 0 = strict barrel (fixed slot rotation, bubble on an ineligible slot); 1 = skip-stalled round-robin.
- RESET_PC, 0: base reset PC.
- PC_STRIDE, 32'h1000: reset PC of thread t = RESET_PC + t*PC_STRIDE.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- thread_en  in  N  per-thread enable mask
- redirect_valid  in  1  PC redirect request
- redirect_tid  in  TID_BITS  redirect target thread
- redirect_pc  in  WIDTH  new PC
- miss_valid  in  1  L1 miss report; stalls miss_tid
- miss_tid  in  TID_BITS  missing thread
- fill_valid  in  1  L1 fill complete; releases fill_tid
- fill_tid  in  TID_BITS  filled thread
- fetch_ready  in  1  downstream accepts fetch slot
- fetch_valid  out  1  slot holds a real thread (0 = bubble)
- fetch_tid  out  TID_BITS  CTID of slot
- fetch_onehot  out  N  one-hot active thread; all zero on bubble
- fetch_pc  out  WIDTH  PC of slot; equals bubble (0) when invalid
- stalled_mask  out  N  current per-thread stall bits

Behaviour:
- Reset (rst_n low at a clk edge):
  - pc[t] = RESET_PC + t*PC_STRIDE; stalled = 0; rr_ptr = 0.
  - fetch_valid = 0, fetch_tid = 0, fetch_onehot = 0, fetch_pc = 0.
  - Reset mid-operation discards the held slot and all stall state.
- Eligibility: elig[t] = thread_en[t] & ~stalled[t], using register values at the current cycle.
- Load condition: load = !fetch_valid || fetch_ready. When fetch_valid && !fetch_ready, all fetch_* outputs hold and rr_ptr holds.
- On load, SCHED_MODE 0:
  - Candidate is rr_ptr only.
  - If elig[rr_ptr], issue it; otherwise load a bubble.
  - rr_ptr advances to (rr_ptr+1) mod N in both cases.
- On load, SCHED_MODE 1:
  - Select the first eligible t scanning rr_ptr, rr_ptr+1, ... mod N.
  - If one is found, issue it and set rr_ptr = (t+1) mod N.
  - If none is found, load a bubble and hold rr_ptr.
- Issue of thread t: next cycle fetch_valid = 1, fetch_tid = t, fetch_onehot = 1<<t, fetch_pc = pc[t]; pc[t] <= pc[t] + 4, wrapping modulo 2^WIDTH.
- Latency: one cycle from state to registered outputs.
- Redirect:
  - pc[redirect_tid] <= redirect_pc next cycle.
  - Takes priority over the +4 increment when the same thread issues in the same cycle.
  - The issued slot carries the old PC; the consumer flushes it.
  - Does not modify a held output slot.
- Miss/fill:
  - miss sets stalled[miss_tid]; fill clears stalled[fill_tid], both effective next cycle.
  - Miss and fill on the same tid in the same cycle: stalled stays 1 (miss wins).
  - Miss on the thread currently being selected does not cancel that issue.
- Disabled thread: never issued and keeps its PC. Its stall bit still updates.
- Out-of-range tid (tid >= N when N is not a power of two): ignored.

Decomposition:
- Extend the shared fgmt package with:
  - THREAD_POOL_SIZE and derived TID_BITS.
  - typedef sched_mode_e {SCHED_BARREL = 0, SCHED_SKIP = 1}.
  - The existing bubble constant and word typedef.
  - A function tid2onehot replacing the fixed PC_T0..PC_T3 constants.
- One sub-module, fgmt_rr_arbiter: a combinational rotating-priority picker over N request bits. Inputs are req and ptr; outputs are grant_valid and grant_tid.

Test Plan (N=4, RESET_PC=0, PC_STRIDE=0x1000, fetch_ready=1 unless stated):
- Reset, thread_en=4'b1111, mode 1 -> fetch_tid sequence 0,1,2,3,0 with fetch_pc 0x0, 0x1000, 0x2000, 0x3000, 0x4; fetch_onehot 0001, 0010, 0100, 1000.
- Mode 1, miss_tid=1 at cycle 2, fill_tid=1 at cycle 8 -> tid 1 skipped (0,2,3,0,2,3…) until fill; tid 1 reappears within 4 cycles after fill; stalled_mask=0010 during the stall.
- Mode 0, same stall -> sequence 0,bubble,2,3,0,bubble… with fetch_valid=0, fetch_onehot=0 and fetch_pc=0 on bubble slots.
- fetch_ready=0 for 3 cycles with slot tid 2 -> outputs frozen at tid 2, pc 0x2000; the next slot after release is tid 3.
- redirect tid 0 to 0x80 in the same cycle tid 0 issues -> that slot shows the old PC; the next tid 0 slot shows 0x80 (not old+4).
- Same-cycle miss and fill on tid 3 -> stalled_mask[3]=1; all threads stalled -> continuous bubbles; rst_n low mid-run -> outputs 0 and PCs restored to reset values next cycle.
